set_bit_enumerator: RTL

//  Inverse of the word OR-reduction: takes a vector whose OR may be set and streams out the index of every
//  set bit, lowest first, one per output beat. Used after a reduced flag fires, to recover which lanes

---
 rtl/lau_pkg.sv | 21 ++
 rtl/trailing_one_idx.sv | 51 +++++
 rtl/set_bit_enumerator.sv | 101 ++++++++++
 3 files changed

// File: rtl/lau_pkg.sv
// Shared lane/arithmetic utilities: encoder architecture selector and
// constant-evaluable integer log2.
package lau_pkg;

    typedef enum logic [1:0] {
        SLOW,
        MEDIUM,
        FAST
    } speed_e;

    // floor(log2(n)) for n >= 1; returns 0 for n <= 1
    function automatic int log2floor(input int n);
        int r;
        r = 0;
        for (int i = 1; i < 31; i++) begin
            if (n >= (1 << i)) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/trailing_one_idx.sv
// Index of the lowest set bit of a, plus an all-zero flag. SLOW is a linear
// priority chain; MEDIUM/FAST reduce (valid, idx) pairs through a binary tree.
module trailing_one_idx
    import lau_pkg::*;
#(
    parameter int     width = 8,
    parameter speed_e speed = FAST,
    localparam int    IW    = (width > 1) ? log2floor(width - 1) + 1 : 1
) (
    input  logic [width-1:0] a,
    output logic [IW-1:0]    idx,
    output logic             zero
);

    if (speed == SLOW) begin : g_linear
        always_comb begin
            idx  = '0;
            zero = ~|a;
            for (int i = width - 1; i >= 0; i--) begin
                if (a[i]) idx = IW'(i);
            end
        end
    end else begin : g_tree
        localparam int P = 1 << IW;

        // Heap layout: node 1 is the root, node k has children 2k and 2k+1,
        // leaf i lives at node P+i. Lanes past width are padded with zeros.
        logic [2*P-1:1] vf;
        logic [IW-1:0]  ixf [1:2*P-1];

        always_comb begin
            vf  = '0;
            ixf = '{default: '0};
            for (int i = 0; i < width; i++) begin
                vf[P+i] = a[i];
            end
            for (int l = IW - 1; l >= 0; l--) begin
                for (int n = 0; n < (1 << l); n++) begin
                    // lower half wins; a hit in the upper half sets this level's index bit
                    vf[(1 << l) + n]  = vf[2*((1 << l) + n)] | vf[2*((1 << l) + n) + 1];
                    ixf[(1 << l) + n] = vf[2*((1 << l) + n)]
                                      ? ixf[2*((1 << l) + n)]
                                      : (ixf[2*((1 << l) + n) + 1] | (IW'(1) << (IW - 1 - l)));
                end
            end
            idx  = ixf[1];
            zero = ~vf[1];
        end
    end

endmodule

// File: rtl/set_bit_enumerator.sv
// Streams the index of every set bit of a captured vector, lowest first, one
// per valid/ready beat. An all-zero vector produces a single "none" beat.
//
// state | meaning
// IDLE  | ready for a new vector, no output beat
// EMIT  | presenting the lowest remaining set bit of pending
module set_bit_enumerator
    import lau_pkg::*;
#(
    parameter int     width = 8,
    parameter speed_e speed = FAST,
    localparam int    IW    = (width > 1) ? log2floor(width - 1) + 1 : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [width-1:0] A_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [IW-1:0]    idx_o,
    output logic             last_o,
    output logic             none_o,
    output logic [IW:0]      beat_o
);

    localparam int BW = IW + 1;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t           state;
    logic [width-1:0] pending;
    logic [IW:0]      beat;

    logic [IW-1:0]    low_idx;
    logic             low_zero;
    logic [width-1:0] pending_cleared;
    logic             last;

    trailing_one_idx #(
        .width (width),
        .speed (speed)
    ) u_encode (
        .a    (pending),
        .idx  (low_idx),
        .zero (low_zero)
    );

    // pending & (pending-1) drops the lowest set bit; zero result means at most one bit left
    assign pending_cleared = pending & (pending - width'(1));
    assign last            = (pending_cleared == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            pending <= '0;
            beat    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        pending <= A_i;
                        beat    <= '0;
                        state   <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready_i) begin
                        if (last) begin
                            state <= IDLE;
                        end else begin
                            pending <= pending_cleared;
                            beat    <= beat + BW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode only registered state, so no input-to-output paths exist.
    always_comb begin
        in_ready_o  = (state == IDLE);
        out_valid_o = (state == EMIT);
        idx_o       = '0;
        last_o      = 1'b0;
        none_o      = 1'b0;
        beat_o      = '0;
        if (state == EMIT) begin
            idx_o  = low_zero ? '0 : low_idx;
            last_o = last;
            none_o = low_zero;
            beat_o = beat;
        end
    end

endmodule
